// File: rtl/mf_control_unit_pkg.sv
// Shared state encoding, opcode constants and decode bundle for the mfhi/mflo control unit.
package mf_control_unit_pkg;

  typedef enum logic [2:0] {
    S_RST,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_PAUSE,
    S_HALT
  } state_t;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 27;
  localparam int OP_W   = OP_MSB - OP_LSB + 1;
  localparam int CNT_W  = 16;

  typedef logic [OP_W-1:0] opcode_t;

  localparam opcode_t OP_MFHI = 5'b11000;
  localparam opcode_t OP_MFLO = 5'b11001;
  localparam opcode_t OP_NOP  = 5'b11010;
  localparam opcode_t OP_HALT = 5'b11011;

  typedef struct packed {
    logic gra;
    logic rin;
    logic hiout;
    logic loout;
    logic illegal;
    logic halt;
  } t3_ctl_t;

  function automatic opcode_t get_opcode(input logic [31:0] ir);
    return ir[OP_MSB:OP_LSB];
  endfunction

endpackage

// File: rtl/mf_control_unit_if.sv
// Control-unit <-> datapath bundle: instruction/handshake inputs and Moore control outputs.
interface mf_control_unit_if;
  import mf_control_unit_pkg::*;

  logic [31:0]      IR;
  logic             stop;
  logic             mem_ready;
  logic             PCout, MARin, IncPC, Zin;
  logic             Zlowout, PCin, Read, MDRin;
  logic             MDRout, IRin;
  logic             Gra, Rin, HIout, LOout;
  logic             run;
  logic             illegal;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  IR, stop, mem_ready,
    output PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin,
           MDRout, IRin, Gra, Rin, HIout, LOout, run, illegal, instr_count
  );

  modport slave (
    output IR, stop, mem_ready,
    input  PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin,
           MDRout, IRin, Gra, Rin, HIout, LOout, run, illegal, instr_count
  );

endinterface

// File: rtl/mf_control_unit_opcode_decode.sv
// Purely combinational T3 decode of the 5-bit opcode; zero latency, no backpressure.
module mf_opcode_decode
  import mf_control_unit_pkg::*;
(
  input  opcode_t opcode_i,
  output t3_ctl_t ctl_o
);

  always_comb begin
    ctl_o = '0;
    case (opcode_i)
      OP_MFHI: begin
        ctl_o.gra   = 1'b1;
        ctl_o.rin   = 1'b1;
        ctl_o.hiout = 1'b1;
      end
      OP_MFLO: begin
        ctl_o.gra   = 1'b1;
        ctl_o.rin   = 1'b1;
        ctl_o.loout = 1'b1;
      end
      OP_NOP:  ctl_o = '0;
      OP_HALT: ctl_o.halt = 1'b1;
      default: ctl_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mf_control_unit.sv
// Moore fetch/execute FSM (T0..T3, PAUSE, HALT) with completed-instruction counter; 4 cycles/instr.
// Optional MF_CU_MEM_WAIT_EN holds T1 until mem_ready; stop pauses only at T0.
module mf_control_unit
  import mf_control_unit_pkg::*;
(
  input  logic              clk,
  input  logic              clear,
  mf_control_unit_if.master bus
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  opcode_t          opcode;
  t3_ctl_t          dec;

  assign opcode = get_opcode(bus.IR);

  mf_opcode_decode u_decode (
    .opcode_i (opcode),
    .ctl_o    (dec)
  );

  logic unused_ir_low;
  assign unused_ir_low = ^bus.IR[OP_LSB-1:0];
`ifndef MF_CU_MEM_WAIT_EN
  logic unused_mem_ready;
  assign unused_mem_ready = bus.mem_ready;
`endif

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q <= S_RST;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    bus.PCout   = 1'b0;
    bus.MARin   = 1'b0;
    bus.IncPC   = 1'b0;
    bus.Zin     = 1'b0;
    bus.Zlowout = 1'b0;
    bus.PCin    = 1'b0;
    bus.Read    = 1'b0;
    bus.MDRin   = 1'b0;
    bus.MDRout  = 1'b0;
    bus.IRin    = 1'b0;
    bus.Gra     = 1'b0;
    bus.Rin     = 1'b0;
    bus.HIout   = 1'b0;
    bus.LOout   = 1'b0;
    bus.illegal = 1'b0;
    bus.run     = (state_q != S_HALT);

    case (state_q)
      S_RST: state_d = S_T0;
      S_T0: begin
        bus.PCout = 1'b1;
        bus.MARin = 1'b1;
        bus.IncPC = 1'b1;
        bus.Zin   = 1'b1;
        state_d   = bus.stop ? S_PAUSE : S_T1;
      end
      S_PAUSE: if (!bus.stop) state_d = S_T0;
      S_T1: begin
        bus.Zlowout = 1'b1;
        bus.PCin    = 1'b1;
        bus.Read    = 1'b1;
        bus.MDRin   = 1'b1;
`ifdef MF_CU_MEM_WAIT_EN
        if (bus.mem_ready) state_d = S_T2;
`else
        state_d = S_T2;
`endif
      end
      S_T2: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
        state_d    = S_T3;
      end
      S_T3: begin
        bus.Gra     = dec.gra;
        bus.Rin     = dec.rin;
        bus.HIout   = dec.hiout;
        bus.LOout   = dec.loout;
        bus.illegal = dec.illegal;
        // Every exit from T3 retires an instruction, halt and illegal included.
        count_d     = count_q + CNT_W'(1);
        state_d     = dec.halt ? S_HALT : S_T0;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_RST;
    endcase
  end

  assign bus.instr_count = count_q;

endmodule

// File: doc/mf_control_unit.md
MF_CONTROL_UNIT -- requirements
Module: mf_control_unit

Interface
REQ-001 SHALL have port clk, input, 1, single system clock; all state changes on its rising edge.
REQ-002 SHALL have port clear, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port IR, input, 32, current instruction register contents from the datapath; opcode is IR[31:27].
REQ-004 SHALL have port stop, input, 1, pause request, sampled only in state T0.
REQ-005 SHALL have port mem_ready, input, 1, memory read-complete strobe; used only when MF_CU_MEM_WAIT_EN is defined.
REQ-006 SHALL have output ports PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin, MDRout, IRin, Gra, Rin, HIout, LOout, each 1 bit, with the same-named datapath control meanings.
REQ-007 SHALL have port run, output, 1, high while the unit is not in HALT.
REQ-008 SHALL have port illegal, output, 1, one-cycle pulse on an undefined opcode.
REQ-009 SHALL have port instr_count, output, 16, count of completed instructions.

Function
REQ-010 SHALL implement the Moore FSM states RST, T0, T1, T2, T3, PAUSE and HALT; control outputs SHALL decode combinationally from state only, plus the opcode in T3.
REQ-011 In RST, all controls SHALL be 0 and run SHALL be 1; the FSM SHALL move to T0 on the next edge.
REQ-012 In T0, PCout, MARin, IncPC and Zin SHALL be 1; if stop=1 the next state SHALL be PAUSE, otherwise T1.
REQ-013 In PAUSE, all controls SHALL be 0; the FSM SHALL return to T0 on the first edge with stop=0.
REQ-014 In T1, Zlowout, PCin, Read and MDRin SHALL be 1; the next state SHALL be T2.
REQ-015 In T2, MDRout and IRin SHALL be 1; the next state SHALL be T3.
REQ-016 In T3, opcode 11000 (mfhi) SHALL assert Gra, Rin and HIout.
REQ-017 In T3, opcode 11001 (mflo) SHALL assert Gra, Rin and LOout.
REQ-018 In T3, opcode 11010 (nop) SHALL assert no controls.
REQ-019 In T3, opcode 11011 (halt) SHALL cause the next state to be HALT.
REQ-020 In T3, any other opcode SHALL assert illegal for exactly that cycle, with Rin=0.
REQ-021 From T3, every opcode except halt SHALL cause the next state to be T0.
REQ-022 HALT SHALL be terminal until clear; in HALT all controls SHALL be 0 and run SHALL be 0.
REQ-023 instr_count SHALL increment by 1 on each edge leaving T3, including halt and illegal opcodes, and SHALL wrap from 0xFFFF to 0x0000.
REQ-024 HIout and LOout SHALL never be asserted in the same cycle, and Rin SHALL be asserted only in T3.

Reset
REQ-025 While clear=1, the state SHALL be RST, instr_count SHALL be 0, illegal SHALL be 0 and run SHALL be 1, regardless of clk.
REQ-026 Assertion of clear in any state, including mid-T1 with Read high, SHALL abort the instruction immediately; the count SHALL NOT increment.

Configuration
REQ-027 With MF_CU_MEM_WAIT_EN defined, T1 SHALL hold with its outputs asserted until mem_ready=1 is sampled, then advance to T2.
REQ-028 Without MF_CU_MEM_WAIT_EN, T1 SHALL last exactly one cycle and mem_ready SHALL be ignored (port still present).

Structure
REQ-029 A shared package SHALL hold the state enumeration, the opcode constants (MFHI, MFLO, NOP, HALT) and the opcode field bounds [31:27].
REQ-030 The opcode-to-T3-control decode SHALL be one sub-module, mf_opcode_decode, which is purely combinational; the FSM and counter SHALL stay in the top module.

Verification
REQ-031 The bench SHALL cover: release clear, IR=0xC0800000 (mfhi, Ra=1) -> T0..T3 in 4 cycles after RST, with Gra=Rin=HIout=1 in T3 and instr_count=1.
REQ-032 The bench SHALL cover: IR=0xC9000000 (mflo, Ra=2) -> LOout=1 and HIout=0 in T3, and back in T0 on the next cycle.
REQ-033 The bench SHALL cover: IR=0xD8000000 (halt) -> HALT after T3, run=0, and all controls 0 for 20 cycles until clear.
REQ-034 The bench SHALL cover: IR=0x38000000 (opcode 00111) -> illegal=1 for one cycle, Rin=0, and instr_count incremented.
REQ-035 The bench SHALL cover: stop=1 during T0 -> PAUSE; stop=0 -> T0, then T1.
REQ-036 The bench SHALL cover, with MF_CU_MEM_WAIT_EN: mem_ready low for 3 cycles -> Read=MDRin=1 held for 4 cycles; clear asserted mid-T1 -> RST with instr_count unchanged at 0.
